accumulator_bank: RTL

//  Parametrised successor of the single-register CPU accumulator: NUM_ACC accumulators

---
 rtl/accumulator_bank_pkg.sv | 31 +++
 rtl/accumulator_bank_alu.sv | 74 +++++++
 rtl/accumulator_bank.sv | 130 +++++++++++++
 3 files changed

// File: rtl/accumulator_bank_pkg.sv
// Shared definitions for accumulator_bank: ALU op encodings, status bit indices, FSM states.
// DATA_WIDTH falls back to 8 when the build does not define it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package accumulator_bank_pkg;

  typedef enum logic [2:0] {
    OP_LD  = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } acc_op_e;

  localparam int ACC_Z = 0;
  localparam int ACC_N = 1;
  localparam int ACC_C = 2;
  localparam int ACC_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } acc_state_e;

endpackage

// File: rtl/accumulator_bank_alu.sv
// Combinational shared ALU for accumulator_bank: (a, b, op) -> (result, {V,C,N,Z}).
// Optional feature: define ACC_SATURATE_EN for unsigned saturating ADD/SUB.
module accumulator_bank_alu
  import accumulator_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [2:0]            i_op,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [3:0]            o_status
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_c;
  logic                  w_v;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // V is taken from the wrapped result so it still reports overflow when saturating
  always_comb begin
    w_res = i_a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (acc_op_e'(i_op))
      OP_LD:  w_res = i_b;
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
`ifdef ACC_SATURATE_EN
        if (w_c) w_res = '1;
`endif
      end
      OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = w_diff[DATA_WIDTH];
        w_v   = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
`ifdef ACC_SATURATE_EN
        if (w_c) w_res = '0;
`endif
      end
      OP_AND: w_res = i_a & i_b;
      OP_OR:  w_res = i_a | i_b;
      OP_XOR: w_res = i_a ^ i_b;
      OP_SHL: begin
        w_res = {i_a[MSB-1:0], 1'b0};
        w_c   = i_a[MSB];
      end
      OP_SHR: begin
        w_res = {1'b0, i_a[MSB:1]};
        w_c   = i_a[0];
      end
      default: w_res = i_a;
    endcase
  end

  always_comb begin
    o_status        = '0;
    o_status[ACC_Z] = (w_res == '0);
    o_status[ACC_N] = w_res[MSB];
    o_status[ACC_C] = w_c;
    o_status[ACC_V] = w_v;
  end

  assign o_result = w_res;

endmodule

// File: rtl/accumulator_bank.sv
// Bank of NUM_ACC accumulators on a CS/WE/OE tristate bus with one shared ALU and a
// start/busy/done repeat engine. Optional feature macro: ACC_SATURATE_EN (see ALU).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module accumulator_bank
  import accumulator_bank_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_ACC    = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  WE,
  input  logic                  OE,
  input  logic [SEL_WIDTH-1:0]  sel,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            status,
  output logic [DATA_WIDTH-1:0] data_out
);

  acc_state_e            r_state;
  acc_state_e            w_nextState;
  logic [DATA_WIDTH-1:0] r_acc [NUM_ACC];
  logic [SEL_WIDTH-1:0]  r_tgt;
  logic [2:0]            r_op;
  logic [DATA_WIDTH-1:0] r_operand;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [3:0]            r_status;
  logic                  w_accept;
  logic                  w_exec;
  logic                  w_busWrite;
  logic [DATA_WIDTH-1:0] w_aluResult;
  logic [3:0]            w_aluStatus;

  assign w_exec     = (r_state == ST_EXEC);
  assign w_busWrite = CS && WE;
  assign data_out   = r_acc[sel];
  assign data       = (CS && OE && !WE) ? r_acc[sel] : 'z;
  assign busy       = w_exec;
  assign done       = (r_state == ST_DONE);
  assign status     = r_status;

  accumulator_bank_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .i_a      (r_acc[r_tgt]),
    .i_b      (r_operand),
    .i_op     (r_op),
    .o_result (w_aluResult),
    .o_status (w_aluStatus)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // A new start is taken from DONE as well as IDLE so back-to-back ops have no gap
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_cnt == '0) w_nextState = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = ST_EXEC;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tgt     <= '0;
      r_op      <= '0;
      r_operand <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_tgt     <= sel;
      r_op      <= op;
      r_operand <= operand;
      r_cnt     <= count;
    end else if (w_exec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_status <= '0;
    else if (w_exec) r_status <= w_aluStatus;
  end

  // The executing target owns its register; a bus write to it during EXEC is lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (w_exec && (r_tgt == SEL_WIDTH'(i)))
          r_acc[i] <= w_aluResult;
        else if (w_busWrite && (sel == SEL_WIDTH'(i)))
          r_acc[i] <= data;
      end
    end
  end

endmodule
